// File: rtl/stage3_pkg.sv
// rtl/stage3_pkg.sv - shared sizes, FSM states and mode helper for the stage-3 scheduler
package stage3_pkg;

  localparam int LANES   = 12;
  localparam int WIDTH   = 16;
  localparam int CNT_W   = 16;
  localparam int MODES   = 8;
  localparam int BATCH_W = 12;
  localparam int MODE_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_onehot(input logic [MODE_W-1:0] m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/stage3_sched_sat_cnt.sv
// rtl/stage3_sched_sat_cnt.sv - per-lane saturating in-interval counter
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/stage3_sched.sv
// rtl/stage3_sched.sv - stage-3 batch scheduler: feeds the compare datapath and tallies per-lane hits
module stage3_sched #(
  parameter int LANES   = stage3_pkg::LANES,
  parameter int WIDTH   = stage3_pkg::WIDTH,
  parameter int CNT_W   = stage3_pkg::CNT_W,
  parameter int MODES   = stage3_pkg::MODES,
  parameter int BATCH_W = stage3_pkg::BATCH_W
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   cfg_valid_i,
  output logic                                   cfg_ready_o,
  input  logic [MODES-1:0][WIDTH-1:0]            cfg_lb_i,
  input  logic [MODES-1:0][WIDTH-1:0]            cfg_ub_i,
  input  logic [WIDTH-1:0]                       cfg_max_score_i,
  input  logic [BATCH_W-1:0]                     cfg_batches_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [LANES-1:0][WIDTH-1:0]            in_score_i,
  input  logic [LANES-1:0][stage3_pkg::MODE_W-1:0] in_mode_i,
  output logic [MODES-1:0][WIDTH-1:0]            dp_lb_o,
  output logic [MODES-1:0][WIDTH-1:0]            dp_ub_o,
  output logic [WIDTH-1:0]                       dp_max_score_o,
  output logic [LANES-1:0][WIDTH-1:0]            dp_score_o,
  output logic [LANES-1:0][stage3_pkg::MODE_W-1:0] dp_mode_o,
  output logic                                   dp_valid_o,
  input  logic [LANES-1:0]                       dp_oob_i,
  output logic                                   res_valid_o,
  input  logic                                   res_ready_i,
  output logic [LANES-1:0][CNT_W-1:0]            res_cnt_o,
  output logic                                   mode_err_o,
  output logic                                   busy_o
);

  import stage3_pkg::*;

  state_e state_q, state_d;

  // One extra bit so a zero batch field can encode 4096 without wrapping.
  logic [BATCH_W:0] target_q, target_d;
  logic [BATCH_W:0] bcnt_q;

  logic [MODES-1:0][WIDTH-1:0]  lb_q, ub_q;
  logic [WIDTH-1:0]             max_q;
  logic [LANES-1:0][WIDTH-1:0]  score_q;
  logic [LANES-1:0][MODE_W-1:0] mode_q;
  logic                         dp_valid_q;
  logic                         mode_err_q;

  logic             cfg_hs, in_hs;
  logic [LANES-1:0] lane_en, lane_bad;

  assign cfg_hs   = cfg_valid_i && cfg_ready_o;
  assign in_hs    = in_valid_i && in_ready_o;
  assign target_d = (cfg_batches_i == '0) ? {1'b1, {BATCH_W{1'b0}}}
                                          : {1'b0, cfg_batches_i};

  always_comb begin
    state_d     = state_q;
    cfg_ready_o = 1'b0;
    in_ready_o  = 1'b0;
    res_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready_o = 1'b1;
        if (cfg_valid_i) state_d = RUN;
      end
      RUN: begin
        in_ready_o = (bcnt_q < target_q);
        if (in_valid_i && in_ready_o && ((bcnt_q + 1'b1) == target_q)) state_d = DRAIN;
      end
      // Wait for the last batch's dp_valid cycle to be counted before reporting.
      DRAIN: begin
        if (!dp_valid_q) state_d = DONE;
      end
      DONE: begin
        res_valid_o = 1'b1;
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane_en  = '0;
    lane_bad = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_bad[i] = !is_onehot(mode_q[i]);
      lane_en[i]  = dp_valid_q && !dp_oob_i[i] && !lane_bad[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      target_q   <= '0;
      bcnt_q     <= '0;
      lb_q       <= '0;
      ub_q       <= '0;
      max_q      <= '0;
      score_q    <= '0;
      mode_q     <= '0;
      dp_valid_q <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dp_valid_q <= in_hs;
      if (in_hs) begin
        score_q <= in_score_i;
        mode_q  <= in_mode_i;
        bcnt_q  <= bcnt_q + 1'b1;
      end
      if (cfg_hs) begin
        lb_q       <= cfg_lb_i;
        ub_q       <= cfg_ub_i;
        max_q      <= cfg_max_score_i;
        target_q   <= target_d;
        bcnt_q     <= '0;
        mode_err_q <= 1'b0;
      end else if (dp_valid_q && (|lane_bad)) begin
        mode_err_q <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (cfg_hs),
      .en_i  (lane_en[g]),
      .cnt_o (res_cnt_o[g])
    );
  end

  assign dp_lb_o        = lb_q;
  assign dp_ub_o        = ub_q;
  assign dp_max_score_o = max_q;
  assign dp_score_o     = score_q;
  assign dp_mode_o      = mode_q;
  assign dp_valid_o     = dp_valid_q;
  assign mode_err_o     = mode_err_q;
  assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_stage3_sched.sv
// tb/tb_stage3_sched.sv - scoreboard bench for stage3_sched (default and 4-bit counter builds)
module tb_stage3_sched;
  import stage3_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst, cfg_valid, in_valid, res_ready;
  logic [MODES-1:0][WIDTH-1:0]  cfg_lb, cfg_ub;
  logic [WIDTH-1:0]             cfg_max;
  logic [BATCH_W-1:0]           cfg_batches;
  logic [LANES-1:0][WIDTH-1:0]  in_score;
  logic [LANES-1:0][MODE_W-1:0] in_mode;
  logic [LANES-1:0]             dp_oob;

  logic                         cfg_ready, in_ready, dp_valid, res_valid, mode_err, busy;
  logic [MODES-1:0][WIDTH-1:0]  dp_lb, dp_ub;
  logic [WIDTH-1:0]             dp_max;
  logic [LANES-1:0][WIDTH-1:0]  dp_score;
  logic [LANES-1:0][MODE_W-1:0] dp_mode;
  logic [LANES-1:0][15:0]       res_cnt;

  logic                         b_cfg_ready, b_in_ready, b_dp_valid, b_res_valid, b_mode_err, b_busy;
  logic [MODES-1:0][WIDTH-1:0]  b_dp_lb, b_dp_ub;
  logic [WIDTH-1:0]             b_dp_max;
  logic [LANES-1:0][WIDTH-1:0]  b_dp_score;
  logic [LANES-1:0][MODE_W-1:0] b_dp_mode;
  logic [LANES-1:0][3:0]        b_res_cnt;

  stage3_sched dut (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_lb_i(cfg_lb), .cfg_ub_i(cfg_ub), .cfg_max_score_i(cfg_max), .cfg_batches_i(cfg_batches),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_score_i(in_score), .in_mode_i(in_mode),
    .dp_lb_o(dp_lb), .dp_ub_o(dp_ub), .dp_max_score_o(dp_max), .dp_score_o(dp_score),
    .dp_mode_o(dp_mode), .dp_valid_o(dp_valid), .dp_oob_i(dp_oob),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_cnt_o(res_cnt),
    .mode_err_o(mode_err), .busy_o(busy)
  );

  stage3_sched #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(b_cfg_ready),
    .cfg_lb_i(cfg_lb), .cfg_ub_i(cfg_ub), .cfg_max_score_i(cfg_max), .cfg_batches_i(cfg_batches),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_score_i(in_score), .in_mode_i(in_mode),
    .dp_lb_o(b_dp_lb), .dp_ub_o(b_dp_ub), .dp_max_score_o(b_dp_max), .dp_score_o(b_dp_score),
    .dp_mode_o(b_dp_mode), .dp_valid_o(b_dp_valid), .dp_oob_i(dp_oob),
    .res_valid_o(b_res_valid), .res_ready_i(res_ready), .res_cnt_o(b_res_cnt),
    .mode_err_o(b_mode_err), .busy_o(b_busy)
  );

  typedef struct {
    logic [LANES-1:0][15:0] cnt;
    logic [LANES-1:0][3:0]  cnt4;
    logic                   err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   hs = 0;
  int   first_cyc = 0;
  int   res_cyc = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LANES-1:0][15:0] fill16(input logic [15:0] v);
    logic [LANES-1:0][15:0] r;
    for (int i = 0; i < LANES; i++) r[i] = v;
    return r;
  endfunction

  function automatic logic [LANES-1:0][3:0] fill4(input logic [3:0] v);
    logic [LANES-1:0][3:0] r;
    for (int i = 0; i < LANES; i++) r[i] = v;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst && in_valid && in_ready) hs = hs + 1;

  // Monitor: pops one expectation per accepted result.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_cnt", res_cnt, e.cnt);
        chk("res_cnt_w4", b_res_cnt, e.cnt4);
        chk("mode_err", mode_err, e.err);
        chk("res_valid_w4", b_res_valid, 1'b1);
      end
    end
  end

  task automatic push_exp(input logic [LANES-1:0][15:0] c, input logic [LANES-1:0][3:0] c4,
                          input logic err);
    exp_t e;
    e.cnt = c; e.cnt4 = c4; e.err = err;
    q.push_back(e);
  endtask

  task automatic do_cfg(input logic [11:0] nb, input logic [15:0] lbv);
    int t = 0;
    @(negedge clk);
    while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("cfg_ready_timeout", 0, 1);
    cfg_valid = 1'b1;
    cfg_batches = nb;
    for (int i = 0; i < MODES; i++) begin
      cfg_lb[i] = lbv + 16'(i);
      cfg_ub[i] = lbv + 16'h0100 + 16'(i);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input int n, input bit gap);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      in_valid = 1'b1;
      for (int i = 0; i < LANES; i++) in_score[i] = 16'h3c00 + 16'(k) + 16'(i * 16);
      @(negedge clk);
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("in_ready_timeout", 0, 1);
      if (k == 0) first_cyc = cyc;
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int t = 0;
    @(negedge clk);
    while (!res_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("res_valid_timeout", 0, 1);
    res_cyc = cyc;
  endtask

  task automatic default_modes();
    for (int i = 0; i < LANES; i++) in_mode[i] = 8'h01 << (i % 8);
    dp_oob = '0;
  endtask

  initial begin
    logic [LANES-1:0][15:0] e16;
    logic [LANES-1:0][3:0]  e4;
    int hs0;

    rst = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    cfg_lb = '0; cfg_ub = '0; cfg_max = 16'h7bff; cfg_batches = '0;
    in_score = '0;
    default_modes();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_dp_valid", dp_valid, 1'b0);
    chk("rst_res_cnt", res_cnt, '0);

    // Three back-to-back batches, every lane in interval.
    push_exp(fill16(16'd3), fill4(4'd3), 1'b0);
    do_cfg(12'd3, 16'h3c00);
    chk("busy_run", busy, 1'b1);
    hs0 = hs;
    send(3, 1'b0);
    @(negedge clk);
    chk("dp_valid_last", dp_valid, 1'b1);
    chk("dp_score_last", dp_score[0], 16'h3c02);
    chk("dp_max", dp_max, 16'h7bff);
    wait_res();
    chk("res_latency", res_cyc - first_cyc, 5);
    chk("hs_3", hs - hs0, 3);

    // Non-one-hot lanes and an out-of-interval lane.
    in_mode[5] = 8'h03; in_mode[7] = 8'h00; dp_oob[0] = 1'b1;
    e16 = fill16(16'd2); e4 = fill4(4'd2);
    e16[0] = 16'd0; e16[5] = 16'd0; e16[7] = 16'd0;
    e4[0] = 4'd0; e4[5] = 4'd0; e4[7] = 4'd0;
    push_exp(e16, e4, 1'b1);
    do_cfg(12'd2, 16'h3800);
    send(2, 1'b0);
    wait_res();
    default_modes();

    // Zero batch field means 4096 batches, valid toggled every other cycle.
    push_exp(fill16(16'd4096), fill4(4'd15), 1'b0);
    do_cfg(12'd0, 16'h3000);
    hs0 = hs;
    send(4096, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", in_ready, 1'b0);
    chk("drain_busy", busy, 1'b1);
    chk("drain_res_valid", res_valid, 1'b0);
    wait_res();
    in_valid = 1'b0;
    chk("hs_4096", hs - hs0, 4096);

    // Saturation of the 4-bit build.
    push_exp(fill16(16'd20), fill4(4'd15), 1'b0);
    do_cfg(12'd20, 16'h3400);
    send(20, 1'b0);
    wait_res();

    // Reset in the middle of a round.
    do_cfg(12'd5, 16'h2c00);
    send(2, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cfg_ready", cfg_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_res_cnt", res_cnt, '0);
    chk("mid_rst_res_cnt_w4", b_res_cnt, '0);
    chk("mid_rst_dp_valid", dp_valid, 1'b0);
    chk("mid_rst_dp_lb", dp_lb, '0);

    // Back-pressure in DONE with a config pulse that must be ignored.
    res_ready = 1'b0;
    push_exp(fill16(16'd1), fill4(4'd1), 1'b0);
    do_cfg(12'd1, 16'h4000);
    send(1, 1'b0);
    wait_res();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        cfg_valid = 1'b1; cfg_batches = 12'd7; cfg_lb[0] = 16'h5555;
      end
      if (i == 6) begin
        chk("done_cfg_ready", cfg_ready, 1'b0);
        cfg_valid = 1'b0;
      end
      chk("done_res_valid", res_valid, 1'b1);
      chk("done_res_cnt", res_cnt, fill16(16'd1));
    end
    chk("done_dp_lb", dp_lb[0], 16'h4000);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt_visible", res_cnt, fill16(16'd1));

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stage3_sched.md
STAGE3_SCHED -- requirements
Module: stage3_sched

Interface
REQ-001 SHALL have parameters: LANES 12 (score lanes per batch); WIDTH 16 (fp16 word); CNT_W 16 (per-lane count width); MODES 8 (one-hot mode intervals); BATCH_W 12 (batch-count field, 0 encodes 4096).
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-003 cfg_valid_i  in  1  configuration offered; cfg_ready_o  out  1  configuration accepted.
REQ-004 cfg_lb_i / cfg_ub_i  in  MODES x WIDTH  fp16 interval lower/upper bounds per mode; cfg_max_score_i  in  WIDTH  fp16 max score.
REQ-005 cfg_batches_i  in  BATCH_W  batches per round (0 = 4096).
REQ-006 in_valid_i  in  1; in_ready_o  out  1; in_score_i  in  LANES x WIDTH  fp16 scores; in_mode_i  in  LANES x 8  one-hot mode per lane.
REQ-007 dp_lb_o / dp_ub_o  out  MODES x WIDTH; dp_max_score_o  out  WIDTH; dp_score_o  out  LANES x WIDTH; dp_mode_o  out  LANES x 8; dp_valid_o  out  1  drive to the combinational stage-3 compare datapath.
REQ-008 dp_oob_i  in  LANES  per-lane out-of-mode-interval flag returned combinationally from the datapath.
REQ-009 res_valid_o  out  1; res_ready_i  in  1; res_cnt_o  out  LANES x CNT_W  in-interval counts; mode_err_o  out  1  sticky non-one-hot mode seen this round; busy_o  out  1.

Function
REQ-010 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-011 IDLE: cfg_ready_o=1, in_ready_o=0; on cfg_valid_i&cfg_ready_o latch bounds, max score, batch target; clear counts, batch counter, mode_err_o; go RUN.
REQ-012 RUN: in_ready_o=1 while accepted batches < target; each input handshake SHALL register scores/modes onto dp_score_o/dp_mode_o with dp_valid_o=1 the next cycle (latency 1), throughput one batch per cycle.
REQ-013 dp_valid_o SHALL be 0 in any cycle following no input handshake; dp_score_o/dp_mode_o hold last value.
REQ-014 On each cycle with dp_valid_o=1, lane i count SHALL increment by 1 iff dp_oob_i[i]=0 and dp_mode_o[i] is one-hot; saturate at 2^CNT_W-1.
REQ-015 Lane with non-one-hot dp_mode_o (including zero) SHALL NOT increment regardless of dp_oob_i and SHALL set mode_err_o.
REQ-016 Handshake accepting the last batch SHALL move RUN->DRAIN; in_ready_o=0 in DRAIN; DRAIN retires the final dp_valid_o cycle then moves to DONE.
REQ-017 DONE: res_valid_o=1, res_cnt_o and mode_err_o stable; on res_ready_i move IDLE; counts remain visible until next config accept.
REQ-018 cfg_batches_i=0 SHALL run exactly 4096 batches; the 13-bit internal counter SHALL NOT wrap.
REQ-019 dp_lb_o/dp_ub_o/dp_max_score_o SHALL come from latched config only; cfg_valid_i outside IDLE SHALL be ignored (cfg_ready_o=0).
REQ-020 busy_o = state != IDLE.

Reset
REQ-021 rst_i SHALL force IDLE and zero every output and register (counts, batch counter, dp_*, mode_err_o, res_valid_o) on the next edge, including mid-RUN; in-flight batch discarded.

Structure
REQ-022 LANES, WIDTH, CNT_W, MODES, BATCH_W and the state enum SHALL live in shared package stage3_pkg.
REQ-023 Per-lane saturating counter SHALL be sub-module sat_cnt (enable, clear, CNT_W parameter), instantiated LANES times.
REQ-024 The block SHALL NOT instantiate fp arithmetic; compare work stays in the datapath.

Verification
REQ-025 Config batches=3, three back-to-back batches, dp_oob_i=0, all modes 8'h01 -> res_cnt_o all 3, mode_err_o=0, res_valid_o 5 cycles after first input handshake.
REQ-026 batches=2, lane 5 mode 8'h03, lane 0 dp_oob_i=1 both batches -> lane 5=0, lane 0=0, others=2, mode_err_o=1.
REQ-027 batches=0, 4096 batches with in_valid_i toggled every other cycle -> exactly 4096 handshakes, counts 4096, in_ready_o=0 in DRAIN.
REQ-028 Count preloaded near saturation via 65540 accepted in-interval batches over 17 rounds? no: CNT_W forced to 4 in bench, 20 batches -> count 15.
REQ-029 rst_i asserted mid-RUN after 2 of 5 batches -> next cycle IDLE, cfg_ready_o=1, res_cnt_o=0, dp_valid_o=0.
REQ-030 res_ready_i held 0 for 10 cycles in DONE, cfg_valid_i pulsed -> res_valid_o held, counts stable, config ignored.
